// File: rtl/mips_store_buffer.sv
// Store buffer between the singleMIPS data port and a handshaked data memory.
// Stores retire into a FIFO and drain in the background; loads forward from it.
module mips_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_we,
  input  logic          core_re,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = AW - 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [WA-1:0] ent_addr_q [DEPTH];
  logic [WA-1:0] ent_addr_d [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];
  logic [DW-1:0] ent_data_d [DEPTH];
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rd_q, rd_d;

  logic          full, empty, push, pop, hit, load_miss;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  // Forwarding scans oldest to youngest so the youngest match wins.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr_q[idx] == core_addr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
    push      = core_we && !full;
    pop       = (state_q == WRITE) && mem_ack;
    load_miss = core_re && !core_we && !hit;
  end

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push) begin
      ent_addr_d[wptr_q] = core_addr[AW-1:2];
      ent_data_d[wptr_q] = core_wdata;
      wptr_d             = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    unique case (state_q)
      IDLE: begin
        // Buffered stores always go out before a missing load.
        if (!empty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {ent_addr_q[rptr_q], 2'b00};
          mem_wdata_d = ent_data_q[rptr_q];
          state_d     = WRITE;
        end else if (load_miss) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {core_addr[AW-1:2], 2'b00};
          state_d    = READ;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      READ: begin
        if (mem_ack) begin
          rd_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    core_rdata = '0;
    if (!reset) begin
      if (core_we) begin
        stall = full;
      end else if (core_re) begin
        if (hit) core_rdata = fwd_data;
        else if (state_q == RESP) core_rdata = rd_q;
        else stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      ent_addr_q  <= '{default: '0};
      ent_data_q  <= '{default: '0};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      ent_addr_q  <= ent_addr_d;
      ent_data_q  <= ent_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mips_store_buffer.sv
// Bench for mips_store_buffer: directed scenarios plus random traffic checked
// against a queue-based store buffer model and an associative-array memory.
module tb_mips_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we = 1'b0, core_re = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mips_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .core_we(core_we), .core_re(core_re),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [29:0] wa; logic [31:0] data;} entry_t;
  entry_t      sb_q[$];
  logic [31:0] mem_model [logic [29:0]];

  int n_asserts = 0, n_fail = 0;
  int txn_count = 0, writes_done = 0, reads_done = 0;
  int lat = 1;
  bit rand_lat = 0, hold_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [29:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return {wa[15:0], 16'hC0DE};
  endfunction

  // Memory responder: ack after a chosen number of request cycles.
  initial begin
    bit busy = 0;
    int cnt = 0, this_lat = 1;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    entry_t h;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; busy = 0;
        chk("req_drop_after_ack", {31'd0, mem_req}, 32'd0);
        if (s_we) begin
          if (sb_q.size() == 0) chk("write_without_entry", 32'd1, 32'd0);
          else begin
            h = sb_q.pop_front();
            chk("write_addr_order", s_addr, {h.wa, 2'b00});
            chk("write_data_order", s_wdata, h.data);
            mem_model[s_addr[31:2]] = s_wdata;
          end
          writes_done++;
        end else reads_done++;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1; cnt = 0; txn_count++;
          s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
          this_lat = rand_lat ? int'($urandom_range(1, 3)) : lat;
          if (!s_we) chk("read_only_when_drained", sb_q.size(), 0);
        end else begin
          chk("mem_stable", {mem_we, mem_addr[30:0]}, {s_we, s_addr[30:0]});
          chk("mem_wdata_stable", mem_wdata, s_wdata);
        end
        cnt++;
        if (cnt >= this_lat && !hold_ack) begin
          mem_ack   = 1'b1;
          mem_rdata = s_we ? 32'h0 : mem_val(s_addr[31:2]);
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic also_re,
                          output int stalls);
    bit exp_stall;
    entry_t e;
    stalls = 0;
    @(negedge clk);
    core_we = 1'b1; core_re = also_re; core_addr = a; core_wdata = d;
    forever begin
      #4;
      exp_stall = (sb_q.size() == DEPTH);
      chk("store_stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("store_rdata", core_rdata, 32'd0);
      @(posedge clk);
      if (!exp_stall) break;
      stalls++;
      if (stalls > 60) begin chk("store_timeout", 32'd1, 32'd0); break; end
      @(negedge clk);
    end
    if (!exp_stall) begin e.wa = a[31:2]; e.data = d; sb_q.push_back(e); end
    #1 core_we = 1'b0; core_re = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    bit hit = 0;
    logic [31:0] fwd = '0;
    int rb;
    stalls = 0;
    @(negedge clk);
    core_re = 1'b1; core_we = 1'b0; core_addr = a;
    #4;
    foreach (sb_q[i]) if (sb_q[i].wa == a[31:2]) begin hit = 1; fwd = sb_q[i].data; end
    if (hit) begin
      chk("hit_stall", {31'd0, stall}, 32'd0);
      chk("hit_rdata", core_rdata, fwd);
      @(posedge clk);
    end else begin
      rb = reads_done;
      chk("miss_first_stall", {31'd0, stall}, 32'd1);
      forever begin
        if (stall === 1'b0) begin
          chk("miss_rdata", core_rdata, mem_val(a[31:2]));
          chk("miss_after_drain", sb_q.size(), 0);
          chk("miss_one_read", reads_done, rb + 1);
          break;
        end
        chk("miss_rdata_zero", core_rdata, 32'd0);
        stalls++;
        if (stalls > 60) begin chk("load_timeout", 32'd1, 32'd0); break; end
        @(posedge clk); @(negedge clk); #4;
      end
      @(posedge clk);
    end
    #1 core_re = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 || mem_req) begin
      @(posedge clk);
      if (++n > 200) begin chk("drain_timeout", 32'd1, 32'd0); break; end
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int s, tb, rb, wb;
    logic [31:0] a, d;
    reset = 1'b1;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    lat = 3; wb = writes_done;
    do_store(32'h10, 32'hA, 0, s); chk("t1_nostall", s, 0);
    do_store(32'h14, 32'hB, 0, s); chk("t1_nostall", s, 0);
    do_store(32'h18, 32'hC, 0, s); chk("t1_nostall", s, 0);
    drain();
    chk("t1_three_writes", writes_done, wb + 3);

    do_store(32'h20, 32'h5, 0, s);
    do_store(32'h20, 32'h7, 0, s);
    do_load(32'h22, s);
    chk("t2_fwd_nostall", s, 0);
    drain();

    hold_ack = 1; lat = 1;
    for (int i = 0; i < 4; i++) do_store(32'h50 + 32'(4 * i), 32'h100 + 32'(i), 0, s);
    fork
      do_store(32'h60, 32'h104, 0, s);
      begin repeat (3) @(posedge clk); hold_ack = 0; end
    join
    chk("t3_full_stalled", {31'd0, (s > 0)}, 32'd1);
    do_load(32'h60, s);
    drain();
    do_load(32'h60, s);

    lat = 2; mem_model[30'h10] = 32'hDEAD;
    do_store(32'h80, 32'h1, 0, s);
    do_store(32'h84, 32'h2, 0, s);
    do_load(32'h40, s);
    do_load(32'h44, s);
    chk("t4_miss_latency", s, lat + 1);

    rb = reads_done;
    do_store(32'h30, 32'h9, 1, s);
    drain();
    chk("t5_no_read", reads_done, rb);
    chk("t5_stored", mem_val(30'hC), 32'h9);

    hold_ack = 1;
    do_store(32'h200, 32'h77, 0, s);
    do_store(32'h204, 32'h78, 0, s);
    for (int i = 0; i < 20 && !mem_req; i++) @(posedge clk);
    chk("t6_in_write", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    core_re = 1'b1; core_addr = 32'h200;
    #2 reset = 1'b1;
    #1;
    chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_rdata", core_rdata, 32'd0);
    sb_q.delete();
    core_re = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; hold_ack = 0;
    tb = txn_count;
    repeat (10) @(posedge clk);
    chk("t6_no_writes", txn_count, tb);
    do_load(32'h200, s);

    rand_lat = 1;
    for (int i = 0; i < 80; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 4))
        0, 1: do_store(a, d, 0, s);
        2:    do_store(a, d, 1, s);
        3:    do_load(a, s);
        default: @(posedge clk);
      endcase
    end
    drain();
    for (int i = 0; i < 8; i++) do_load(32'h100 + 32'(4 * i), s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
